// File: rtl/seqdet_stream_ctrl.sv
// ============================================================================
// Module  : seqdet_stream_ctrl
// Brief   : Serial pattern-detector sequencer. Takes parallel words over a
//           valid/ready handshake and shifts them MSB-first into a PAT_LEN-bit
//           history. Counts overlapping PATTERN matches across a multi-word
//           frame, then presents the saturating count on a valid/ready port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seqdet_stream_ctrl #(
    parameter int                 WORD_W  = 8,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    input  logic              out_ready,
    output logic              match,
    output logic              busy
);

    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [WORD_W-1:0]   word_q;
    logic                last_q;
    logic [IDX_W-1:0]    idx;
    logic [PAT_LEN-1:0]  history;
    logic [FILL_W-1:0]   fill;
    logic [CNT_W-1:0]    count;
    logic                match_pulse;

    logic                cur_bit;
    logic [PAT_LEN-1:0]  next_history;
    logic [FILL_W-1:0]   next_fill;
    logic                hit;

    // Bit currently being shifted in, taken from the latched word MSB-first.
    assign cur_bit = word_q[idx];

    // A single-bit history has no older bits to keep, so it needs its own form.
    generate
        if (PAT_LEN == 1) begin : g_hist_single
            assign next_history = cur_bit;
        end else begin : g_hist_multi
            assign next_history = {history[PAT_LEN-2:0], cur_bit};
        end
    endgenerate

    // Fill tracks how many valid bits the history holds; it stops at PAT_LEN.
    assign next_fill = (fill == FILL_W'(PAT_LEN)) ? fill : fill + 1'b1;

    // The fill guard keeps the cleared history from matching (e.g. PATTERN=0).
    assign hit = (next_history == PATTERN) && (next_fill == FILL_W'(PAT_LEN));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (idx == '0) begin
                    state_next = last_q ? REPORT : IDLE;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: word capture, bit shifting, match counting and frame clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q      <= '0;
            last_q      <= 1'b0;
            idx         <= '0;
            history     <= '0;
            fill        <= '0;
            count       <= '0;
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_q <= in_word;
                        last_q <= in_last;
                        idx    <= IDX_W'(WORD_W - 1);
                    end
                end
                SHIFT: begin
                    history     <= next_history;
                    fill        <= next_fill;
                    idx         <= idx - 1'b1;
                    match_pulse <= hit;
                    if (hit && (count != {CNT_W{1'b1}})) begin
                        count <= count + 1'b1;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        count   <= '0;
                        history <= '0;
                        fill    <= '0;
                    end
                end
                default: begin
                    match_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign out_count = count;
    assign match     = match_pulse;

endmodule

`default_nettype wire

// File: tb/tb_seqdet_stream_ctrl.sv
// ============================================================================
// Module  : tb_seqdet_stream_ctrl
// Brief   : Self-checking bench. Two instances share one stimulus stream:
//           A uses the default pattern 1001 / 8-bit count, B uses pattern 0000
//           with a 2-bit saturating count. Expectations come from a bit-queue
//           model of each frame.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seqdet_stream_ctrl;

    localparam int         W     = 8;
    localparam logic [3:0] PAT_A = 4'b1001;
    localparam logic [3:0] PAT_B = 4'b0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_word;
    logic         in_last;
    logic         out_ready;

    logic         in_ready_a, out_valid_a, match_a, busy_a;
    logic [7:0]   out_count_a;
    logic         in_ready_b, out_valid_b, match_b, busy_b;
    logic [1:0]   out_count_b;

    seqdet_stream_ctrl #(.WORD_W(W), .PAT_LEN(4), .PATTERN(PAT_A), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_last(in_last),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_count(out_count_a),
        .out_ready(out_ready), .match(match_a), .busy(busy_a)
    );

    seqdet_stream_ctrl #(.WORD_W(W), .PAT_LEN(4), .PATTERN(PAT_B), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_last(in_last),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_count(out_count_b),
        .out_ready(out_ready), .match(match_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    bit bits[$];          // every bit shifted so far in the current frame, oldest first
    int cnt_a = 0;
    int cnt_b = 0;
    int last_accept = 0;
    bit aborted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Does the window of 4 bits ending at frame bit k equal the pattern?
    function automatic bit hit(input int k, input logic [3:0] pat);
        if (k < 3) return 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (bits[k-3+j] != pat[3-j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sat_a();
        return (cnt_a > 255) ? 255 : cnt_a;
    endfunction

    function automatic int sat_b();
        return (cnt_b > 3) ? 3 : cnt_b;
    endfunction

    // Check the match pulse caused by frame bit k (negative k: no pulse expected).
    task automatic check_match(input int k);
        bit ea, eb;
        ea = (k >= 0) ? hit(k, PAT_A) : 1'b0;
        eb = (k >= 0) ? hit(k, PAT_B) : 1'b0;
        cnt_a += int'(ea);
        cnt_b += int'(eb);
        check("match_a", match_a, ea);
        check("match_b", match_b, eb);
    endtask

    // Offer one word; called and returns on a falling edge. abort_at>=0 pulses
    // rst during that shift cycle. exp_gap>0 checks the spacing from the
    // previous acceptance.
    task automatic send_word(input logic [W-1:0] w, input bit last, input bit hold,
                             input int abort_at, input int exp_gap);
        int n = 0;
        int base;
        aborted  = 1'b0;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        while (!in_ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            aborted  = 1'b1;
            return;
        end
        check("in_ready_b", in_ready_b, 1);
        @(negedge clk);                       // cycle T, first shift cycle
        if (exp_gap > 0) check("accept_gap", cyc - last_accept, exp_gap);
        last_accept = cyc;
        if (!hold || last) in_valid = 1'b0;
        base = bits.size();
        for (int i = 0; i < W; i++) bits.push_back(w[W-1-i]);
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge clk);
            if (i == abort_at) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check("rst_out_valid", out_valid_a, 0);
                check("rst_busy", busy_a, 0);
                check("rst_in_ready", in_ready_a, 1);
                check("rst_count_a", out_count_a, 0);
                check("rst_count_b", out_count_b, 0);
                check("rst_match", {match_a, match_b}, 0);
                bits.delete();
                cnt_a   = 0;
                cnt_b   = 0;
                aborted = 1'b1;
                return;
            end
            check("shift_busy", {busy_a, busy_b}, 2'b11);
            check("shift_in_ready", {in_ready_a, in_ready_b}, 0);
            check_match((i == 0) ? -1 : base + i - 1);
        end
        @(negedge clk);                       // cycle T+W
        check_match(base + W - 1);
        if (!last) begin
            check("word_in_ready", {in_ready_a, in_ready_b}, 2'b11);
            check("word_out_valid", {out_valid_a, out_valid_b}, 0);
        end else begin
            check("last_out_valid", {out_valid_a, out_valid_b}, 2'b11);
            check("last_count_a", out_count_a, sat_a());
            check("last_count_b", out_count_b, sat_b());
            check("last_in_ready", in_ready_a, 0);
        end
    endtask

    // Hold off the result for 'stall' cycles, then hand it off.
    task automatic take_result(input int stall);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid_a, 1);
            check("stall_count_a", out_count_a, sat_a());
            check("stall_count_b", out_count_b, sat_b());
            check("stall_in_ready", in_ready_a, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", {out_valid_a, out_valid_b}, 0);
        check("post_in_ready", in_ready_a, 1);
        check("post_busy", busy_a, 0);
        check("post_count", {out_count_a, out_count_b}, 0);
        bits.delete();
        cnt_a = 0;
        cnt_b = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_match", match_a, 0);
        check("reset_count", out_count_a, 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready_a, 1);

        // Overlapping matches in one word.
        send_word(8'b10010010, 1'b1, 1'b0, -1, 0);
        take_result(0);
        // Match spanning a word boundary.
        send_word(8'b00000010, 1'b0, 1'b0, -1, 0);
        send_word(8'b01000000, 1'b1, 1'b0, -1, 0);
        take_result(0);
        // No matches; result stalled for 5 cycles.
        send_word(8'hFF, 1'b1, 1'b0, -1, 0);
        take_result(5);
        // All zeros: saturation on the 2-bit counter.
        send_word(8'h00, 1'b1, 1'b0, -1, 0);
        take_result(0);
        // Reset mid-shift, then a clean frame.
        send_word(8'b10010010, 1'b1, 1'b0, 3, 0);
        send_word(8'b00010010, 1'b1, 1'b0, -1, 0);
        take_result(0);
        // Back-to-back with in_valid held high.
        send_word(8'b10011001, 1'b0, 1'b1, -1, 0);
        send_word(8'b00100100, 1'b0, 1'b1, -1, W + 1);
        send_word(8'b10000001, 1'b1, 1'b1, -1, W + 1);
        take_result(1);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            int nw;
            int ab;
            nw = $urandom_range(1, 3);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, W - 1) : -1;
            for (int k = 0; k < nw; k++) begin
                logic [W-1:0] w;
                case ($urandom_range(0, 3))
                    0:       w = 8'h00;
                    1:       w = {4'b1001, 4'($urandom)};
                    default: w = 8'($urandom);
                endcase
                send_word(w, k == nw - 1, 1'($urandom), (k == 0) ? ab : -1, 0);
                if (aborted) break;
            end
            if (!aborted) take_result($urandom_range(0, 3));
            in_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
